// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle for rf_wb_arbiter: two valid/ready sources
// (port 0 = ALU, port 1 = load/store unit), each carrying a destination register and data.
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wb0_valid;
    logic [ADDR_WIDTH-1:0] wb0_rd;
    logic [DATA_WIDTH-1:0] wb0_data;
    logic                  wb0_ready;
    logic                  wb1_valid;
    logic [ADDR_WIDTH-1:0] wb1_rd;
    logic [DATA_WIDTH-1:0] wb1_data;
    logic                  wb1_ready;

    modport master (
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter plus pending-write scoreboard for the register file.
// Define RF_WB_BYPASS_EN to add fwd_a/fwd_b bypass of the write in flight.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Wrclk,
    input  logic                  Rst_n,
    rf_wb_arbiter_if.slave        wb,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_rd,
    input  logic [ADDR_WIDTH-1:0] Ra,
    input  logic [ADDR_WIDTH-1:0] Rb,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [ADDR_WIDTH-1:0] Rw,
    output logic [DATA_WIDTH-1:0] busW,
    output logic                  RegWr
`ifdef RF_WB_BYPASS_EN
    ,
    output logic [DATA_WIDTH-1:0] fwd_a,
    output logic [DATA_WIDTH-1:0] fwd_b
`endif
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic             prio_r;
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             hit_a_s;
    logic             hit_b_s;

    // Port prio wins a tie; a lone requester always wins.
    assign grant0_s = wb.wb0_valid & (~wb.wb1_valid | ~prio_r);
    assign grant1_s = wb.wb1_valid & (~wb.wb0_valid |  prio_r);

    assign wb.wb0_ready = grant0_s;
    assign wb.wb1_ready = grant1_s;

    // Scoreboard next state: reservation overrides a same-edge commit, x0 never busy.
    always_comb begin
        busy_nxt_s = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            busy_nxt_s[i] = (rsv_valid & (rsv_rd == ADDR_WIDTH'(i)))
                          | (busy_r[i] & ~(RegWr & (Rw == ADDR_WIDTH'(i))));
        end
    end

    // Output stage, priority pointer and scoreboard registers.
    always_ff @(posedge Wrclk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_r <= 1'b0;
            RegWr  <= 1'b0;
            Rw     <= {ADDR_WIDTH{1'b0}};
            busW   <= {DATA_WIDTH{1'b0}};
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            if (grant0_s) begin
                Rw     <= wb.wb0_rd;
                busW   <= wb.wb0_data;
                RegWr  <= (wb.wb0_rd != {ADDR_WIDTH{1'b0}});
                prio_r <= 1'b1;
            end else if (grant1_s) begin
                Rw     <= wb.wb1_rd;
                busW   <= wb.wb1_data;
                RegWr  <= (wb.wb1_rd != {ADDR_WIDTH{1'b0}});
                prio_r <= 1'b0;
            end else begin
                RegWr  <= 1'b0;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // The write sitting on the file port this cycle can be forwarded instead of stalling.
    assign hit_a_s = RegWr & (Rw == Ra) & (Ra != {ADDR_WIDTH{1'b0}});
    assign hit_b_s = RegWr & (Rw == Rb) & (Rb != {ADDR_WIDTH{1'b0}});
    assign fwd_a   = hit_a_s ? busW : {DATA_WIDTH{1'b0}};
    assign fwd_b   = hit_b_s ? busW : {DATA_WIDTH{1'b0}};
`else
    assign hit_a_s = 1'b0;
    assign hit_b_s = 1'b0;
`endif

    assign busy_a = busy_r[Ra] & ~hit_a_s;
    assign busy_b = busy_r[Rb] & ~hit_b_s;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard in front of the 32-entry register file. Two write-back sources (port 0: ALU, port 1: load/store unit) compete for the register file's single write port. This block grants them round-robin, registers the winning write onto the file's `Rw`/`busW`/`RegWr` inputs, and tracks which destination registers have writes still in flight. Decode queries the scoreboard to stall on read-after-write hazards.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register address width; the scoreboard has 2**ADDR_WIDTH bits.
- `DATA_WIDTH`, 32: write data width.

Ports:
- `Wrclk` input, 1: clock; all state updates on the rising edge.
- `Rst_n` input, 1: reset, asynchronous, active-low.
- `wb0_valid` input, 1: port 0 write-back request.
- `wb0_rd` input, ADDR_WIDTH: port 0 destination register.
- `wb0_data` input, DATA_WIDTH: port 0 write data.
- `wb0_ready` output, 1: port 0 granted this cycle (combinational).
- `wb1_valid`, `wb1_rd`, `wb1_data`, `wb1_ready`: same as port 0, for port 1.
- `rsv_valid` input, 1: decode issues an instruction that writes `rsv_rd`.
- `rsv_rd` input, ADDR_WIDTH: register to mark busy.
- `Ra` input, ADDR_WIDTH: hazard query address A.
- `Rb` input, ADDR_WIDTH: hazard query address B.
- `busy_a` output, 1: register `Ra` has a pending write (combinational).
- `busy_b` output, 1: register `Rb` has a pending write (combinational).
- `Rw` output, ADDR_WIDTH: register file write address (registered).
- `busW` output, DATA_WIDTH: register file write data (registered).
- `RegWr` output, 1: register file write enable (registered).
- `fwd_a`, `fwd_b` output, DATA_WIDTH: bypass data; present only with `RF_WB_BYPASS_EN`.

## Operation
- **Handshake.** A transfer occurs on port n when `wbn_valid && wbn_ready` at a rising edge.
  - A source holds `valid`, `rd` and `data` stable until accepted.
  - `ready` never depends on the state of the output stage; the arbiter accepts one request per cycle with no backpressure.
- **Arbitration.** A 1-bit priority pointer `prio` selects the favoured port.
  - Both ports valid: grant port `prio`.
  - One port valid: grant that port.
  - After any grant: `prio <= ~granted_port`.
  - No grant: `prio` holds.
- **Output stage.** A granted request is captured at the edge into `Rw`/`busW`, with `RegWr <= (rd != 0)`.
  - With no grant, `RegWr <= 0`; `Rw` and `busW` hold their previous values.
- **x0 writes.** A write to x0 is accepted and consumed but never raises `RegWr` and never touches the scoreboard.
- **Scoreboard.** `busy[i]` is 1 bit per register.
  - Set: `rsv_valid && rsv_rd != 0` sets `busy[rsv_rd]`.
  - Clear: a cycle with `RegWr=1` clears `busy[Rw]`.
  - Set and clear of the same register at the same edge: set wins, because the newly issued writer supersedes.
  - `busy[0]` is always 0.
  - `busy_a = busy[Ra]`; `busy_b = busy[Rb]`.
- **Scoreboard depth.** Only one outstanding writer per register is tracked. Decode must not reserve a register that is already busy; a second reservation has no additional effect.
- **Reset values.** On `Rst_n` low, asynchronously: `RegWr=0`, `Rw=0`, `busW=0`, all `busy=0`, `prio=0`. Any in-flight request is dropped and its scoreboard bit is lost; the pipeline flushes on reset.

## Timing
- **Latency.** A request is accepted at edge k. `RegWr`/`Rw`/`busW` are valid in cycle k+1, and the register file commits at edge k+1.
- **Scoreboard timing.** `busy` clears at edge k+1, so `busy_a`/`busy_b` fall in cycle k+2.
  - A read of the file in cycle k+2 sees the new value.
- **Throughput.** One write per cycle. With both ports continuously valid, grants alternate 0,1,0,1 starting from `prio`.
- **Reservation timing.** `rsv` asserted at edge k makes busy visible in cycle k+1.
- **Combinational paths.** `wbn_ready` depends only on `wb0_valid`, `wb1_valid` and `prio`. `busy_a`/`busy_b` depend only on `Ra`, `Rb` and the registered state.

## Configuration
- **`RF_WB_BYPASS_EN` defined:**
  - `busy_a` is forced to 0 when `RegWr && Rw == Ra && Ra != 0`, with `fwd_a = busW`; `fwd_b` likewise for `Rb`.
  - Otherwise `fwd_a`/`fwd_b` = 0.
  - This removes the one-cycle hazard bubble in cycle k+1.
- **Not defined:** the `fwd_a`/`fwd_b` ports are absent. `busy` stays asserted through cycle k+1 as described in Timing.

## Test plan
- **Reset:** assert `Rst_n=0` mid-cycle with `RegWr=1` pending → `RegWr`, `Rw`, `busW` and all `busy` are 0 immediately; after release, the first simultaneous request grants port 0.
- **Single write:** `rsv rd=5`, then `wb0` writes x5=0xDEADBEEF → `RegWr=1`, `Rw=5`, `busW=0xDEADBEEF` one cycle after accept; `busy_a` (`Ra=5`) goes 1→0 in cycle k+2.
- **Contention:** both ports valid for 4 cycles (rd 1–4 on port 0, rd 11–14 on port 1) → commit order 1,11,2,12; each loser holds `ready=0` until it is granted.
- **x0 write:** `wb1` writes x0=0x1234 → `wb1_ready=1`, `RegWr` stays 0, `busy[0]` stays 0.
- **Set/clear collision:** x7 commits while `rsv rd=7` is asserted at the same edge → `busy[7]` remains 1.
- **Bypass (macro on):** `Ra=9` while `RegWr=1`, `Rw=9`, `busW=0x55` → `busy_a=0`, `fwd_a=0x55`. With the macro off, the same stimulus gives `busy_a=1`.
